// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush/forward sequencer for a 5-stage
//               (F, D, E, M, W) in-order pipeline.
//               - Drives hold (stall) and clear (flush) controls of every
//                 inter-stage register. stall=1 holds, flush=1 loads zero.
//               - Resolves load-use hazards, taken-branch redirects and
//                 multi-cycle data-memory waits. Priority, highest first:
//                 memory wait > branch > load-use.
//               - Generates the E-stage operand forwarding selects.
//               Optional feature macro: HAZARD_PERF_EN
//                 defined   -> adds stall_cycles, flush_events and
//                              mem_wait_cycles performance counters
//                 undefined -> those ports and counters are absent
// Parameters  : REG_ADDR_W   register index width
//               MISS_TIMEOUT max consecutive memory-wait cycles before
//                            mem_err is raised
//               CNT_W        performance counter width
// Ports       : clk                          rising-edge clock
//               rst                          synchronous reset, active low
//               rs1_d, rs2_d                 source regs of the D instr
//               rs1_e, rs2_e                 source regs of the E instr
//               rd_e, rd_m, rd_w             dest regs in E / M / W
//               load_e                       E instr is a load
//               regwrite_m, regwrite_w       M / W instr writes its rd
//               pcsrc_e                      taken branch/jump resolved in E
//               mem_busy_m                   data memory not ready for M
//               stall_f/d/e/m                hold PC, IF-ID, ID-EX, EX-MEM
//               flush_d/e/w                  clear IF-ID, ID-EX, MEM-WB
//               fwd_a_e, fwd_b_e             00 regfile, 10 from M, 01 from W
//               mem_err                      sticky memory-timeout flag
//               stall_cycles, flush_events,
//               mem_wait_cycles              perf counters (HAZARD_PERF_EN)
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rs1_e,
   input  logic [REG_ADDR_W-1:0] rs2_e,
   input  logic [REG_ADDR_W-1:0] rd_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  load_e,
   input  logic                  regwrite_m,
   input  logic                  regwrite_w,
   input  logic                  pcsrc_e,
   input  logic                  mem_busy_m,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  stall_e,
   output logic                  stall_m,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic                  flush_w,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events,
   output logic [CNT_W-1:0]      mem_wait_cycles
`endif
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------------
   if (MISS_TIMEOUT < 1) begin : g_chk_timeout
      $error("pipeline_hazard_ctrl: MISS_TIMEOUT must be at least 1");
   end

   if (CNT_W < 1) begin : g_chk_cnt_w
      $error("pipeline_hazard_ctrl: CNT_W must be at least 1");
   end

   // ------------------------------------------------------------------------
   // Constants and state
   // ------------------------------------------------------------------------
   // Counter wide enough to hold MISS_TIMEOUT itself (saturation value).
   localparam int c_wcnt_w = $clog2(MISS_TIMEOUT + 1);
   localparam logic [c_wcnt_w-1:0] c_miss_timeout = c_wcnt_w'(MISS_TIMEOUT);
   localparam logic [c_wcnt_w-1:0] c_wcnt_one     = c_wcnt_w'(1);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_wcnt_w-1:0]   r_wait_cnt;
   logic                  r_pend_br;
   logic                  r_mem_err;

   state_t                w_next_state;
   logic [c_wcnt_w-1:0]   w_wait_cnt_next;
   logic                  w_pend_br_next;
   logic                  w_err_set;
   logic                  w_load_use;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_load_use = load_e && (rd_e != '0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));

   // ------------------------------------------------------------------------
   // Stall / flush sequencing (outputs are combinational from state+inputs)
   // ------------------------------------------------------------------------
   always_comb begin
      stall_f         = 1'b0;
      stall_d         = 1'b0;
      stall_e         = 1'b0;
      stall_m         = 1'b0;
      flush_d         = 1'b0;
      flush_e         = 1'b0;
      flush_w         = 1'b0;
      w_next_state    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_pend_br_next  = r_pend_br;
      w_err_set       = 1'b0;

      if (rst) begin
         unique case (r_state)
            ST_RUN: begin
               if (mem_busy_m) begin
                  // Full freeze; the instr in M must not retire into W, so
                  // MEM-WB is cleared instead of held.
                  stall_f         = 1'b1;
                  stall_d         = 1'b1;
                  stall_e         = 1'b1;
                  stall_m         = 1'b1;
                  flush_w         = 1'b1;
                  w_next_state    = ST_MEM_WAIT;
                  w_wait_cnt_next = c_wcnt_one;
                  // A redirect seen in the first frozen cycle must survive
                  // until the release cycle as well.
                  w_pend_br_next  = pcsrc_e;
                  w_err_set       = (c_wcnt_one == c_miss_timeout);
               end else if (pcsrc_e) begin
                  // The D instr is wrong-path and gets squashed, which also
                  // makes any load-use hazard against it irrelevant.
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (w_load_use) begin
                  // Hold F and D one cycle, inject a single bubble into E.
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end

            ST_MEM_WAIT: begin
               if (mem_busy_m) begin
                  stall_f        = 1'b1;
                  stall_d        = 1'b1;
                  stall_e        = 1'b1;
                  stall_m        = 1'b1;
                  flush_w        = 1'b1;
                  // Redirects are remembered, not acted on, while frozen.
                  w_pend_br_next = r_pend_br | pcsrc_e;
                  if (r_wait_cnt != c_miss_timeout) begin
                     w_wait_cnt_next = r_wait_cnt + c_wcnt_one;
                  end
                  w_err_set = (w_wait_cnt_next == c_miss_timeout);
               end else begin
                  // Release cycle: stalls drop and any redirect seen during
                  // the freeze is applied now.
                  flush_d         = pcsrc_e | r_pend_br;
                  flush_e         = pcsrc_e | r_pend_br;
                  w_next_state    = ST_RUN;
                  w_wait_cnt_next = '0;
                  w_pend_br_next  = 1'b0;
               end
            end

            default: begin
               w_next_state = ST_RUN;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registered sequencer state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_pend_br  <= 1'b0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_wait_cnt_next;
         r_pend_br  <= w_pend_br_next;
         if (w_err_set) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   assign mem_err = r_mem_err;

   // ------------------------------------------------------------------------
   // E-stage operand forwarding (M has priority: it holds the newer value)
   // ------------------------------------------------------------------------
   always_comb begin
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;

      if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e)) begin
         fwd_a_e = 2'b10;
      end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e)) begin
         fwd_a_e = 2'b01;
      end

      if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e)) begin
         fwd_b_e = 2'b10;
      end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e)) begin
         fwd_b_e = 2'b01;
      end
   end

`ifdef HAZARD_PERF_EN
   // ------------------------------------------------------------------------
   // Performance counters (wrap naturally at 2^CNT_W)
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;
   logic [CNT_W-1:0] r_mem_wait_cycles;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cycles    <= '0;
         r_flush_events    <= '0;
         r_mem_wait_cycles <= '0;
      end else begin
         if (stall_f) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end
         // flush_d is only ever raised by a redirect, so it marks exactly
         // the branch-caused flush_e cycles (load-use bubbles excluded).
         if (flush_d) begin
            r_flush_events <= r_flush_events + 1'b1;
         end
         if (r_state == ST_MEM_WAIT) begin
            r_mem_wait_cycles <= r_mem_wait_cycles + 1'b1;
         end
      end
   end

   assign stall_cycles    = r_stall_cycles;
   assign flush_events    = r_flush_events;
   assign mem_wait_cycles = r_mem_wait_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//               model tracks the length of the current memory-wait episode,
//               a pending-redirect flag and the sticky error flag, and
//               derives the expected controls for every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int RW = 5;
   localparam int MT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          load_e, regwrite_m, regwrite_w, pcsrc_e, mem_busy_m;
   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_e, flush_w;
   logic [1:0]    fwd_a_e, fwd_b_e;
   logic          mem_err;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W   (RW),
      .MISS_TIMEOUT (MT),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rs1_d      (rs1_d),
      .rs2_d      (rs2_d),
      .rs1_e      (rs1_e),
      .rs2_e      (rs2_e),
      .rd_e       (rd_e),
      .rd_m       (rd_m),
      .rd_w       (rd_w),
      .load_e     (load_e),
      .regwrite_m (regwrite_m),
      .regwrite_w (regwrite_w),
      .pcsrc_e    (pcsrc_e),
      .mem_busy_m (mem_busy_m),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .stall_e    (stall_e),
      .stall_m    (stall_m),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .flush_w    (flush_w),
      .fwd_a_e    (fwd_a_e),
      .fwd_b_e    (fwd_b_e),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;

   // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,mem_err,fwd_a,fwd_b}
   logic [11:0] obs_vec;
   logic [11:0] exp_vec;
   assign obs_vec = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                     flush_w, mem_err, fwd_a_e, fwd_b_e};

   // Model state: in_wait = previous cycle was frozen; wait_len = number of
   // consecutive busy cycles in the current episode.
   bit m_in_wait, m_pend, m_err;
   int m_wait_len;
   bit x_in_wait, x_pend, x_err;
   int x_wait_len;

   function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
      if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_eval();
      bit sf, sd, se, sm, fd, fe, fw, lu;
      sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0;
      x_in_wait = m_in_wait; x_wait_len = m_wait_len; x_pend = m_pend; x_err = m_err;
      lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      if (!rst) begin
         x_in_wait = 0; x_wait_len = 0; x_pend = 0; x_err = 0;
      end else if (mem_busy_m) begin
         sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
         x_in_wait = 1;
         x_wait_len = m_wait_len + 1;
         x_pend = m_pend | pcsrc_e;
         if (x_wait_len >= MT) x_err = 1;
      end else if (m_in_wait) begin
         fd = pcsrc_e | m_pend;
         fe = fd;
         x_in_wait = 0; x_wait_len = 0; x_pend = 0;
      end else if (pcsrc_e) begin
         fd = 1; fe = 1;
      end else if (lu) begin
         sf = 1; sd = 1; fe = 1;
      end
      exp_vec = {sf, sd, se, sm, fd, fe, fw, m_err, fwd_ref(rs1_e), fwd_ref(rs2_e)};
   endtask

   task automatic model_commit();
      m_in_wait = x_in_wait; m_wait_len = x_wait_len; m_pend = x_pend; m_err = x_err;
   endtask

   task automatic drv(input logic r, input logic ld, input logic [RW-1:0] rde,
                      input logic [RW-1:0] r1d, input logic [RW-1:0] r2d,
                      input logic [RW-1:0] r1e, input logic [RW-1:0] r2e,
                      input logic [RW-1:0] rdm, input logic [RW-1:0] rdw,
                      input logic rwm, input logic rww, input logic pc, input logic busy);
      rst = r; load_e = ld; rd_e = rde; rs1_d = r1d; rs2_d = r2d;
      rs1_e = r1e; rs2_e = r2e; rd_m = rdm; rd_w = rdw;
      regwrite_m = rwm; regwrite_w = rww; pcsrc_e = pc; mem_busy_m = busy;
   endtask

   task automatic idle();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset suppresses every stall/flush even with all hazards present.
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drv(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1);
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL reset cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) drv(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else        idle();
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL load_use cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   task automatic test_x0();
      drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      #1 model_eval();
      n_vec++;
      if (obs_vec !== exp_vec) begin
         n_miss++;
         $display("FAIL x0: got %b want %b", obs_vec, exp_vec);
      end
      model_commit(); @(negedge clk);
   endtask

   task automatic test_fwd_priority();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drv(1, 0, 0, 0, 0, 7, 3, 7, 7, 1, 1, 0, 0);
            1: drv(1, 0, 0, 0, 0, 7, 3, 7, 3, 0, 1, 0, 0);
            default: drv(1, 0, 0, 0, 0, 9, 9, 9, 9, 0, 1, 0, 0);
         endcase
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL fwd_priority cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   task automatic test_branch_vs_loaduse();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) drv(1, 1, 6, 0, 6, 0, 0, 0, 0, 0, 0, 1, 0);
         else        idle();
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL branch_vs_loaduse cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   // Busy 4 cycles, redirect during the 2nd, then release and one idle cycle.
   task automatic test_mem_wait_branch();
      for (int i = 0; i < 6; i++) begin
         idle();
         mem_busy_m = (i < 4);
         pcsrc_e    = (i == 1);
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL mem_wait_branch cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   task automatic test_timeout_reset();
      for (int i = 0; i < 12; i++) begin
         idle();
         mem_busy_m = (i < 11);
         rst        = (i != 10);
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL timeout_reset cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         n_vec++;
         if (i == 9 && mem_err !== 1'b1) begin
            n_miss++;
            $display("FAIL timeout_err_set: got %b want 1", mem_err);
         end else if (i == 11 && (mem_err !== 1'b0 || stall_f !== 1'b0)) begin
            n_miss++;
            $display("FAIL timeout_err_clear: got err=%b stall_f=%b want 0 0", mem_err, stall_f);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   task automatic test_random();
      bit busy_prev = 0;
      for (int i = 0; i < 500; i++) begin
         drv(($urandom_range(0, 49) != 0), 1'($urandom), RW'($urandom_range(0, 3)),
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             busy_prev ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) == 0));
         busy_prev = mem_busy_m;
         #1 model_eval();
         n_vec++;
         if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL random cyc%0d: got %b want %b", i, obs_vec, exp_vec);
         end
         model_commit(); @(negedge clk);
      end
   endtask

   initial begin
      m_in_wait = 0; m_pend = 0; m_err = 0; m_wait_len = 0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_load_use();
      test_x0();
      test_fwd_priority();
      test_branch_vs_loaduse();
      test_mem_wait_branch();
      test_timeout_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
